// File: rtl/tick_scheduler.sv
// Tick scheduler: programmable tick divider plus a round-robin, quantum-limited
// ownership arbiter that advances only on divided ticks.
module tick_scheduler #(
   parameter int N_REQ       = 4,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 25,
   parameter int QUANTUM     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] grant,
   output logic [2:0]       owner_id,
   output logic             busy,
   output logic             tick,
   output logic             owner_tick,
   output logic             clk_out
);

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
   localparam logic [7:0]       Q_LAST  = 8'(QUANTUM - 1);
   localparam logic [2:0]       LG_RST  = 3'(N_REQ - 1);

   typedef enum logic {S_IDLE, S_OWNED} state_t;

   logic [DIV_W-1:0] cnt_q, div_act_q, div_pend_q;
   logic             tick_q, clk_q, owner_tick_q;
   logic [N_REQ-1:0] grant_q;
   logic [2:0]       owner_q, last_q;
   logic             busy_q;
   logic [7:0]       slot_q;
   state_t           state_q;

   logic             wrap;
   logic             rel;
   logic             busy_nx;
   logic [3:0]       idle_pk, pre_pk;

   // Round-robin search: first set bit strictly after base, wrapping.
   // Returns {found, index}.
   function automatic logic [3:0] rr_pick(input logic [N_REQ-1:0] v,
                                          input logic [2:0] base);
      logic [3:0] r;
      r = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         int k;
         k = int'(base) + i;
         if (k >= N_REQ) k = k - N_REQ;
         if (!r[3] && v[k]) r = {1'b1, 3'(k)};
      end
      return r;
   endfunction

   assign wrap    = (cnt_q == div_act_q);
   // Owner lets go through done or by dropping its request line.
   assign rel     = |(grant_q & (done | ~req));
   assign idle_pk = rr_pick(req, last_q);
   assign pre_pk  = rr_pick(req & ~grant_q, owner_q);

   // Next-cycle busy, so owner_tick lines up with the busy seen alongside tick.
   always_comb begin
      busy_nx = busy_q;
      if (state_q == S_IDLE) busy_nx = tick_q && idle_pk[3];
      else if (rel)          busy_nx = 1'b0;
   end

   // Divider: count to div_active, wrap, and issue a registered tick after the wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         div_act_q    <= DEF_DIV;
         div_pend_q   <= DEF_DIV;
         tick_q       <= 1'b0;
         clk_q        <= 1'b0;
         owner_tick_q <= 1'b0;
      end else begin
         cnt_q        <= wrap ? '0 : cnt_q + DIV_W'(1);
         if (cfg_we) div_pend_q <= cfg_div;
         // New divide only takes effect at a period boundary; a write in the
         // wrap cycle itself is forwarded straight in.
         if (wrap) div_act_q <= cfg_we ? cfg_div : div_pend_q;
         tick_q       <= wrap;
         clk_q        <= clk_q ^ wrap;
         owner_tick_q <= wrap & busy_nx;
      end
   end

   // Ownership FSM: grant on tick, hold for a quantum, preempt or release.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         slot_q  <= '0;
         last_q  <= LG_RST;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (tick_q && idle_pk[3]) begin
                  state_q <= S_OWNED;
                  grant_q <= N_REQ'(1) << idle_pk[2:0];
                  owner_q <= idle_pk[2:0];
                  busy_q  <= 1'b1;
                  slot_q  <= '0;
               end
            end
            S_OWNED: begin
               // Release beats a coincident preempt; the next grant waits for a tick.
               if (rel) begin
                  state_q <= S_IDLE;
                  grant_q <= '0;
                  owner_q <= '0;
                  busy_q  <= 1'b0;
                  slot_q  <= '0;
                  last_q  <= owner_q;
               end else if (tick_q) begin
                  if (slot_q == Q_LAST) begin
                     // Quantum spent: hand over only if someone else is waiting.
                     if (pre_pk[3]) begin
                        grant_q <= N_REQ'(1) << pre_pk[2:0];
                        owner_q <= pre_pk[2:0];
                        last_q  <= owner_q;
                        slot_q  <= '0;
                     end
                  end else begin
                     slot_q <= slot_q + 8'd1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign grant      = grant_q;
   assign owner_id   = owner_q;
   assign busy       = busy_q;
   assign tick       = tick_q;
   assign owner_tick = owner_tick_q;
   assign clk_out    = clk_q;

endmodule
